// File: rtl/oled_spi_driver.sv
// SSD1306-style OLED power sequencer and write-only SPI (mode 3) byte serialiser.
// Define OLED_SIM_FAST_EN to shorten every power-up delay to 2 cycles for simulation.
module oled_spi_driver #(
   parameter int CLK_DIV           = 4,
   parameter int VDD_DELAY_CYCLES  = 8,
   parameter int RES_LOW_CYCLES    = 16,
   parameter int RES_HIGH_CYCLES   = 8,
   parameter int VBAT_DELAY_CYCLES = 32
) (
   input  logic       i_clk_x4,
   input  logic       i_rst,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic       i_cmd_is_data,
   input  logic [7:0] i_cmd_byte,
   output logic       o_init_done,
   output logic       o_sdin,
   output logic       o_sclk,
   output logic       o_dc,
   output logic       o_res,
   output logic       o_vbat,
   output logic       o_vdd
);

   // state      | meaning
   // S_OFF      | supplies off, one cycle after reset
   // S_VDD_ON   | logic supply on, settling
   // S_RES_LOW  | panel reset asserted
   // S_RES_HIGH | panel reset released, settling
   // S_VBAT_ON  | panel supply on, settling
   // S_IDLE     | ready for a byte
   // S_SHIFT    | serialising a byte, MSB first

   localparam int CNT_W = 16;

`ifdef OLED_SIM_FAST_EN
   localparam int VDD_D  = 2;
   localparam int RL_D   = 2;
   localparam int RH_D   = 2;
   localparam int VBAT_D = 2;
`else
   localparam int VDD_D  = VDD_DELAY_CYCLES;
   localparam int RL_D   = RES_LOW_CYCLES;
   localparam int RH_D   = RES_HIGH_CYCLES;
   localparam int VBAT_D = VBAT_DELAY_CYCLES;
`endif

   // Counter runs from N-1 down to 0, so a zero delay still costs one cycle.
   localparam logic [CNT_W-1:0] VDD_LD  = CNT_W'(((VDD_D  < 1) ? 1 : VDD_D)  - 1);
   localparam logic [CNT_W-1:0] RL_LD   = CNT_W'(((RL_D   < 1) ? 1 : RL_D)   - 1);
   localparam logic [CNT_W-1:0] RH_LD   = CNT_W'(((RH_D   < 1) ? 1 : RH_D)   - 1);
   localparam logic [CNT_W-1:0] VBAT_LD = CNT_W'(((VBAT_D < 1) ? 1 : VBAT_D) - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_OFF, S_VDD_ON, S_RES_LOW, S_RES_HIGH, S_VBAT_ON, S_IDLE, S_SHIFT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic             r_phase, w_phase_nxt;
   logic             r_sclk, w_sclk_nxt;
   logic             r_sdin, w_sdin_nxt;
   logic             r_dc, w_dc_nxt;
   logic             w_cnt_zero;
   logic [CNT_W-1:0] w_cnt_dec;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_dec  = r_cnt - CNT_W'(1);

   always_ff @(posedge i_clk_x4) begin
      if (i_rst) begin
         r_state <= S_OFF;
         r_cnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_phase <= 1'b0;
         r_sclk  <= 1'b1;
         r_sdin  <= 1'b0;
         r_dc    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_phase <= w_phase_nxt;
         r_sclk  <= w_sclk_nxt;
         r_sdin  <= w_sdin_nxt;
         r_dc    <= w_dc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_phase_nxt = r_phase;
      w_sclk_nxt  = r_sclk;
      w_sdin_nxt  = r_sdin;
      w_dc_nxt    = r_dc;
      case (r_state)
         S_OFF: begin
            w_state_nxt = S_VDD_ON;
            w_cnt_nxt   = VDD_LD;
         end
         S_VDD_ON: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_RES_LOW;
               w_cnt_nxt   = RL_LD;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_RES_LOW: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_RES_HIGH;
               w_cnt_nxt   = RH_LD;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_RES_HIGH: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_VBAT_ON;
               w_cnt_nxt   = VBAT_LD;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_VBAT_ON: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_IDLE: begin
            if (i_cmd_valid) begin
               w_state_nxt = S_SHIFT;
               w_shift_nxt = i_cmd_byte;
               w_dc_nxt    = i_cmd_is_data;
               w_sdin_nxt  = i_cmd_byte[7];
               w_sclk_nxt  = 1'b0;
               w_phase_nxt = 1'b0;
               w_bit_nxt   = 3'd7;
               w_cnt_nxt   = DIV_LD;
            end
         end
         S_SHIFT: begin
            // phase 0 = SCLK low half, phase 1 = SCLK high half of the current bit
            if (!w_cnt_zero) begin
               w_cnt_nxt = w_cnt_dec;
            end else if (!r_phase) begin
               w_sclk_nxt  = 1'b1;
               w_phase_nxt = 1'b1;
               w_cnt_nxt   = DIV_LD;
            end else if (r_bit == 3'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_sclk_nxt  = 1'b0;
               w_sdin_nxt  = r_shift[6];
               w_shift_nxt = {r_shift[6:0], 1'b0};
               w_bit_nxt   = r_bit - 3'd1;
               w_phase_nxt = 1'b0;
               w_cnt_nxt   = DIV_LD;
            end
         end
         default: begin
            w_state_nxt = S_OFF;
         end
      endcase
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_init_done = (r_state == S_IDLE) || (r_state == S_SHIFT);
   assign o_vdd       = (r_state == S_OFF);
   assign o_res       = (r_state != S_RES_LOW);
   assign o_vbat      = !((r_state == S_VBAT_ON) || o_init_done);
   assign o_sclk      = r_sclk;
   assign o_sdin      = r_sdin;
   assign o_dc        = r_dc;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Directed bench for oled_spi_driver: power-up timing, byte serialisation, reset mid-byte.
// Expected power-up timing follows OLED_SIM_FAST_EN when the build defines it.
module tb_oled_spi_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_is_data = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic       cmd_ready, init_done, sdin, sclk, dc, res, vbat, vdd;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef OLED_SIM_FAST_EN
   localparam int E_VDD = 2, E_RL = 2, E_RH = 2, E_VB = 2;
`else
   localparam int E_VDD = 8, E_RL = 16, E_RH = 8, E_VB = 32;
`endif
   localparam int E_RES_FIRST = 1 + E_VDD;
   localparam int E_RES_LAST  = E_VDD + E_RL;
   localparam int E_VBAT      = 1 + E_VDD + E_RL + E_RH;
   localparam int E_INIT      = E_VBAT + E_VB;
   localparam int E_XFER      = 1 + 16 * 4;

   oled_spi_driver dut (
      .i_clk_x4      (clk),
      .i_rst         (rst),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_is_data (cmd_is_data),
      .i_cmd_byte    (cmd_byte),
      .o_init_done   (init_done),
      .o_sdin        (sdin),
      .o_sclk        (sclk),
      .o_dc          (dc),
      .o_res         (res),
      .o_vbat        (vbat),
      .o_vdd         (vdd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_vdd"}, 32'(vdd), 1);
      chk({tag, "_vbat"}, 32'(vbat), 1);
      chk({tag, "_res"}, 32'(res), 1);
      chk({tag, "_sclk"}, 32'(sclk), 1);
      chk({tag, "_sdin"}, 32'(sdin), 0);
      chk({tag, "_dc"}, 32'(dc), 0);
      chk({tag, "_ready"}, 32'(cmd_ready), 0);
      chk({tag, "_init"}, 32'(init_done), 0);
   endtask

   // Called in cycle 0 (state just reset); releases rst and times the sequence,
   // offering a byte 8'h55 while the panel supply settles.
   task automatic powerup(input string tag);
      int vdd_f = -1, res_f = -1, res_l = -1, vbat_f = -1, init_c = -1, lows = 0;
      rst = 1'b0;
      cmd_valid = 1'b0;
      for (int c = 1; c < 400; c++) begin
         step();
         if (vdd == 1'b0 && vdd_f < 0) vdd_f = c;
         if (res == 1'b0) begin
            if (res_f < 0) res_f = c;
            res_l = c;
         end
         if (vbat == 1'b0 && vbat_f < 0) vbat_f = c;
         if (sclk == 1'b0) lows++;
         if (init_done) begin
            init_c = c;
            break;
         end
         if (cmd_ready) chk({tag, "_early_ready"}, 32'(cmd_ready), 0);
         cmd_valid = (c >= E_VBAT && c < E_INIT - 1);
         cmd_byte  = 8'h55;
      end
      cmd_valid = 1'b0;
      chk({tag, "_vdd_fall"}, 32'(vdd_f), 32'(1));
      chk({tag, "_res_first"}, 32'(res_f), 32'(E_RES_FIRST));
      chk({tag, "_res_last"}, 32'(res_l), 32'(E_RES_LAST));
      chk({tag, "_vbat_fall"}, 32'(vbat_f), 32'(E_VBAT));
      chk({tag, "_init_cycle"}, 32'(init_c), 32'(E_INIT));
      chk({tag, "_ready_at_init"}, 32'(cmd_ready), 1);
      chk({tag, "_no_sclk"}, 32'(lows), 0);
      chk({tag, "_dc_not_latched"}, 32'(dc), 0);
      chk({tag, "_sdin_not_latched"}, 32'(sdin), 0);
   endtask

   // Called just after the accept edge (cycle T+1); follows the byte until ready returns.
   task automatic watch(output logic [7:0] got, output int cyc, output int rises,
                        output logic dc_first, output logic dc_changed);
      logic prev;
      got = 8'h00;
      cyc = 1;
      rises = 0;
      dc_first = dc;
      dc_changed = 1'b0;
      prev = sclk;
      while (!cmd_ready && cyc < 300) begin
         step();
         cyc++;
         if (!prev && sclk) begin
            got = {got[6:0], sdin};
            rises++;
         end
         if (dc !== dc_first) dc_changed = 1'b1;
         prev = sclk;
      end
   endtask

   logic [7:0] got;
   int         cyc, rises;
   logic       dcf, dcc;

   initial begin
      step();
      step();
      chk_reset("rst");
      powerup("pu1");

      // single command byte; input changes after accept must not matter
      cmd_valid = 1'b1; cmd_byte = 8'hA5; cmd_is_data = 1'b0;
      step();
      cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_is_data = 1'b1;
      chk("a5_ready_drop", 32'(cmd_ready), 0);
      watch(got, cyc, rises, dcf, dcc);
      chk("a5_byte", 32'(got), 32'h A5);
      chk("a5_rises", 32'(rises), 8);
      chk("a5_cycles", 32'(cyc), 32'(E_XFER));
      chk("a5_dc", 32'(dcf), 0);
      chk("a5_dc_stable", 32'(dcc), 0);
      chk("a5_sclk_idle", 32'(sclk), 1);
      chk("a5_sdin_hold", 32'(sdin), 1);

      // back-to-back: AF command then 3C data, cmd_valid held high
      cmd_valid = 1'b1; cmd_byte = 8'hAF; cmd_is_data = 1'b0;
      step();
      cmd_byte = 8'h3C; cmd_is_data = 1'b1;
      watch(got, cyc, rises, dcf, dcc);
      chk("b2b1_byte", 32'(got), 32'h AF);
      chk("b2b1_rises", 32'(rises), 8);
      chk("b2b1_cycles", 32'(cyc), 32'(E_XFER));
      chk("b2b1_dc", 32'(dcf), 0);
      chk("b2b1_sclk_idle", 32'(sclk), 1);
      step();
      cmd_valid = 1'b0;
      chk("b2b2_sclk_low", 32'(sclk), 0);
      watch(got, cyc, rises, dcf, dcc);
      chk("b2b2_byte", 32'(got), 32'h 3C);
      chk("b2b2_rises", 32'(rises), 8);
      chk("b2b2_cycles", 32'(cyc), 32'(E_XFER));
      chk("b2b2_dc", 32'(dcf), 1);
      chk("b2b2_dc_stable", 32'(dcc), 0);

      // reset after the third SCLK rising edge of 8'hFF; reset beats cmd_valid
      cmd_valid = 1'b1; cmd_byte = 8'hFF; cmd_is_data = 1'b1;
      step();
      cmd_valid = 1'b0;
      rises = 0;
      for (int k = 0; k < 100 && rises < 3; k++) begin
         logic p;
         p = sclk;
         step();
         if (!p && sclk) rises++;
      end
      chk("ff_three_rises", 32'(rises), 3);
      rst = 1'b1; cmd_valid = 1'b1;
      step();
      chk_reset("midrst");
      powerup("pu2");

      // driver works again after the restart
      cmd_valid = 1'b1; cmd_byte = 8'hA5; cmd_is_data = 1'b1;
      step();
      cmd_valid = 1'b0;
      watch(got, cyc, rises, dcf, dcc);
      chk("post_byte", 32'(got), 32'h A5);
      chk("post_cycles", 32'(cyc), 32'(E_XFER));
      chk("post_dc", 32'(dcf), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/oled_spi_driver.md
OLED_SPI_DRIVER -- requirements
Module: oled_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clkX4 cycles, legal range 2..255.
REQ-002 Parameter VDD_DELAY_CYCLES, default 8: wait after logic-supply enable.
REQ-003 Parameter RES_LOW_CYCLES, default 16: RES low pulse width; RES_HIGH_CYCLES, default 8: wait after RES release.
REQ-004 Parameter VBAT_DELAY_CYCLES, default 32: wait after panel-supply enable.
REQ-005 clkX4  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmdValid  in  1  upstream byte request.
REQ-008 cmdReady  out  1  driver can accept a byte this cycle.
REQ-009 cmdIsData  in  1  DC value for the byte: 1=display data, 0=command.
REQ-010 cmdByte  in  8  byte to serialise.
REQ-011 initDone  out  1  power-up sequence complete.
REQ-012 SDIN  out  1  SPI data, MSB first.
REQ-013 SCLK  out  1  SPI clock, idle high (mode 3).
REQ-014 DC  out  1  data/command select.
REQ-015 RES  out  1  panel reset, active-low.
REQ-016 VBAT / VDD  out  1 each  panel / logic supply enables, active-low (0=on).

Function
REQ-017 FSM states: OFF, VDD_ON, RES_LOW, RES_HIGH, VBAT_ON, IDLE, SHIFT; one down-counter shared by all timed states.
REQ-018 OFF: entered on reset; next cycle -> VDD_ON.
REQ-019 VDD_ON: VDD=0 for VDD_DELAY_CYCLES cycles -> RES_LOW; VDD stays 0 thereafter.
REQ-020 RES_LOW: RES=0 for RES_LOW_CYCLES cycles -> RES_HIGH (RES=1) for RES_HIGH_CYCLES cycles -> VBAT_ON.
REQ-021 VBAT_ON: VBAT=0 for VBAT_DELAY_CYCLES cycles -> IDLE; VBAT stays 0 thereafter.
REQ-022 initDone rises on first IDLE cycle, exactly VDD+RES_LOW+RES_HIGH+VBAT delay cycles after VDD falls; remains 1 until reset.
REQ-023 cmdReady=1 only in IDLE; cmdValid outside IDLE ignored, byte not latched, no SPI activity.
REQ-024 Accept when cmdValid&&cmdReady in cycle T: cmdByte and cmdIsData latched; cmdReady=0 from T+1.
REQ-025 From T+1: DC=latched cmdIsData, held until next accept; per bit, SCLK low CLK_DIV cycles then high CLK_DIV cycles; SDIN updates only with SCLK falling edge; bit7 first.
REQ-026 After bit0 high phase: IDLE, cmdReady=1 at cycle T+1+16*CLK_DIV; SCLK high, SDIN holds bit0.
REQ-027 Back-to-back: accept in first IDLE cycle allowed; no extra idle gap required.
REQ-028 cmdByte/cmdIsData changes during SHIFT have no effect on current byte.
REQ-029 rst during any state, including mid-byte: next cycle all outputs at reset values, FSM OFF, partial byte discarded, full power-up restarts.
REQ-030 Delay parameter of 0 treated as 1 cycle.

Reset
REQ-031 Reset values: VDD=1, VBAT=1, RES=1, SCLK=1, SDIN=0, DC=0, cmdReady=0, initDone=0, counter=0, latches=0.
REQ-032 Reset wins over cmdValid in the same cycle.

Configuration
REQ-033 Macro OLED_SIM_FAST_EN: when defined, VDD_DELAY_CYCLES, RES_LOW_CYCLES, RES_HIGH_CYCLES and VBAT_DELAY_CYCLES all forced to 2 (power-up 8 cycles); CLK_DIV and SPI timing unchanged.
REQ-034 Macro undefined: parameter values used as given; no other behavioural difference.

Verification (defaults, macro undefined unless stated)
REQ-035 Release rst -> VDD falls cycle 1; RES low cycles 9-24; VBAT falls cycle 33; initDone=1 and cmdReady=1 at cycle 65.
REQ-036 In IDLE send cmdByte=8'hA5, cmdIsData=0 -> DC=0, 8 SCLK rising edges sample SDIN 1,0,1,0,0,1,0,1; cmdReady back 65 cycles after accept.
REQ-037 Two back-to-back bytes 8'hAF (cmd) then 8'h3C (data) with cmdValid held high -> DC 0 then 1, 16 rising edges, no SCLK glitch between bytes.
REQ-038 Assert rst for 1 cycle after 3rd SCLK rising edge of 8'hFF -> next cycle VDD=VBAT=RES=SCLK=1, cmdReady=0; power-up repeats; no further SCLK edges until new byte.
REQ-039 cmdValid=1 with 8'h55 during VBAT_ON -> no SCLK activity; byte dropped; cmdReady only at cycle 65.
REQ-040 OLED_SIM_FAST_EN defined -> initDone=1 8 cycles after VDD falls; byte 8'hA5 still takes 16*CLK_DIV cycles.
